// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, data-memory wait freeze
// with timeout, and saturating stall/flush event counters.
module hazard_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_Rs1,
    input  logic [4:0]  IF_ID_Rs2,
    input  logic        IF_ID_UsesRs1,
    input  logic        IF_ID_UsesRs2,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_Rd,
    input  logic        EX_BranchTaken,
    input  logic        EX_MEM_MemAccess,
    input  logic        DMemReady,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        EX_MEM_Write,
    output logic        ID_EX_Bubble,
    output logic        MEM_WB_Bubble,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        MemTimeout,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic mem_freeze;
    logic load_use;
    logic do_flush;
    logic do_stall;

    assign mem_freeze = EX_MEM_MemAccess && !DMemReady;
    assign load_use   = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                        ((IF_ID_UsesRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                         (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    // A taken branch outranks a load-use hazard; both yield to a frozen pipe.
    assign do_flush = (state_q != ST_ERR) && !mem_freeze && EX_BranchTaken;
    assign do_stall = (state_q != ST_ERR) && !mem_freeze && !EX_BranchTaken && load_use;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_freeze) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_freeze) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == '1) begin
                    state_d    = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (do_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Mealy control outputs from state and current hazards
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        ID_EX_Bubble  = 1'b0;
        MEM_WB_Bubble = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        if (state_q == ST_ERR) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
        end else if (mem_freeze) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
        end else if (do_flush) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (do_stall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign MemTimeout = (state_q == ST_ERR);
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus random
// stimulus compared against a behavioural model of the hazard rules.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
    logic        IF_ID_UsesRs1, IF_ID_UsesRs2, ID_EX_MemRead;
    logic        EX_BranchTaken, EX_MEM_MemAccess, DMemReady;
    logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic        ID_EX_Bubble, MEM_WB_Bubble, IF_ID_Flush, ID_EX_Flush;
    logic        MemTimeout;
    logic [15:0] StallCount, FlushCount;

    int errors = 0;
    int checks = 0;

    // Model: error flag, run length of consecutive frozen cycles, event totals
    bit m_err;
    int m_frozen_run;
    int m_stalls;
    int m_flushes;

    hazard_control_unit dut (
        .clk(clk), .rst(rst),
        .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
        .IF_ID_UsesRs1(IF_ID_UsesRs1), .IF_ID_UsesRs2(IF_ID_UsesRs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_BranchTaken(EX_BranchTaken), .EX_MEM_MemAccess(EX_MEM_MemAccess),
        .DMemReady(DMemReady),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
        .ID_EX_Bubble(ID_EX_Bubble), .MEM_WB_Bubble(MEM_WB_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check mid-cycle, clock, advance model
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mr,
                        input logic [4:0] rd, input logic br, input logic ma,
                        input logic rdy, input logic r, input bit do_chk);
        bit freeze, lu, flush, stall;
        logic [7:0] exp_ctrl;
        IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2; IF_ID_UsesRs1 = u1; IF_ID_UsesRs2 = u2;
        ID_EX_MemRead = mr; ID_EX_Rd = rd; EX_BranchTaken = br;
        EX_MEM_MemAccess = ma; DMemReady = rdy; rst = r;
        #3;
        freeze = ma && !rdy;
        lu     = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
        flush  = !m_err && !freeze && br;
        stall  = !m_err && !freeze && !br && lu;
        // order: PCWrite IF_ID_Write ID_EX_Write EX_MEM_Write ID_EX_Bubble MEM_WB_Bubble IF_ID_Flush ID_EX_Flush
        if (m_err)       exp_ctrl = 8'b0000_0000;
        else if (freeze) exp_ctrl = 8'b0000_0100;
        else if (flush)  exp_ctrl = 8'b1111_0011;
        else if (stall)  exp_ctrl = 8'b0011_1000;
        else             exp_ctrl = 8'b1111_0000;
        if (do_chk) begin
            check("ctrl", 32'({PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                               ID_EX_Bubble, MEM_WB_Bubble, IF_ID_Flush, ID_EX_Flush}),
                  32'(exp_ctrl));
            check("MemTimeout", 32'(MemTimeout), 32'(m_err));
            check("StallCount", 32'(StallCount), 32'(m_stalls));
            check("FlushCount", 32'(FlushCount), 32'(m_flushes));
        end
        @(posedge clk);
        if (r) begin
            m_err = 0; m_frozen_run = 0; m_stalls = 0; m_flushes = 0;
        end else if (!m_err) begin
            if (freeze) begin
                m_frozen_run++;
                if (m_frozen_run >= 256) m_err = 1;
            end else begin
                m_frozen_run = 0;
            end
            if (stall && m_stalls < 65535) m_stalls++;
            if (flush && m_flushes < 65535) m_flushes++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    endtask

    initial begin
        m_err = 0; m_frozen_run = 0; m_stalls = 0; m_flushes = 0;
        // Power-up reset: model state is not yet meaningful, so no checks here
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);

        // Load-use on Rs2
        step(1, 5, 0, 1, 1, 5, 0, 0, 1, 0, 1);
        idle(1);
        check("lu_stallcount", 32'(StallCount), 32'd1);
        // Register-0 destination never stalls
        step(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1);
        check("r0_nostall", 32'(StallCount), 32'd1);
        // Unused source must not stall
        step(5, 0, 0, 0, 1, 5, 0, 0, 1, 0, 1);
        do_reset();
        // Branch with simultaneous load-use: flush wins
        step(7, 0, 1, 0, 1, 7, 1, 0, 1, 0, 1);
        idle(1);
        check("br_flushcount", 32'(FlushCount), 32'd1);
        check("br_stallcount", 32'(StallCount), 32'd0);
        // Three frozen cycles with a pending branch, then release
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
        idle(1);
        check("wait_flushcount", 32'(FlushCount), 32'd2);
        // Timeout: 256 frozen cycles reach ERR, then hold there
        for (int i = 0; i < 256; i++) step(3, 0, 1, 0, 1, 3, 1, 1, 0, 0, 1);
        check("timeout_flag", 32'(MemTimeout), 32'd1);
        step(3, 0, 1, 0, 1, 3, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        do_reset();
        check("reset_clears_timeout", 32'(MemTimeout), 32'd0);
        idle(1);
        // 255 frozen cycles stay just short of the timeout
        for (int i = 0; i < 255; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        idle(1);
        // Saturation: 65,537 load-use cycles
        for (int i = 0; i < 65537; i++) step(9, 0, 1, 0, 1, 9, 0, 0, 1, 0, 1);
        check("stall_saturated", 32'(StallCount), 32'hFFFF);
        step(9, 0, 1, 0, 1, 9, 0, 0, 1, 0, 1);
        do_reset();

        // Random phase with small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
